// File: rtl/bf_out_fifo_if.sv
// Sink-side handshake bundle for the BF output FIFO.
//   tx_data  : head byte presented to the sink
//   tx_valid : tx_data holds a buffered byte
//   tx_ready : sink accepts tx_data this cycle
// master = FIFO (drives data/valid), slave = sink (drives ready).
interface bf_out_fifo_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/bf_out_fifo.sv
// bf_out_fifo: output stage behind the BF core.
// Captures every byte the core emits (out/out_enable) into a DEPTH-entry FIFO and
// drains it to a sink over a valid/ready handshake. The core cannot stall, so a byte
// arriving at a full FIFO (with no pop in the same cycle) is dropped and the sticky
// overflow flag is raised. A small drain FSM reports when a halted program's output
// has completely left the FIFO.
//
// Ports:
//   clock, reset_n        clock (rising edge), async active-low reset
//   out, out_enable       byte from the core and its one-cycle strobe
//   halted                core halted flag
//   tx (master)           tx_data / tx_valid / tx_ready sink handshake
//   overflow              sticky drop flag, cleared by overflow_clear
//   overflow_clear        clears overflow (a same-cycle drop wins)
//   drained               registered: drain FSM in DONE and FIFO empty
//
// Optional build macro BF_OUT_FIFO_COUNT_EN adds:
//   count [PTR_SIZE:0]    occupancy (wr_ptr - rd_ptr), 0..DEPTH
//   almost_full           count >= DEPTH-2
module bf_out_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [7:0]                out,
  input  logic                      out_enable,
  input  logic                      halted,
  bf_out_fifo_if.master             tx,
  output logic                      overflow,
  input  logic                      overflow_clear,
  output logic                      drained
`ifdef BF_OUT_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      almost_full
`endif
);

  localparam int unsigned PTR_SIZE = $clog2(DEPTH);
  localparam int unsigned PW       = PTR_SIZE + 1;

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_DRAIN = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [7:0]          mem_q [DEPTH];
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                overflow_q, overflow_d;
  logic                drained_q, drained_d;
  logic [1:0]          state_q, state_d;

  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic                drop;
  logic [PTR_SIZE-1:0] wr_idx;
  logic [PTR_SIZE-1:0] rd_idx_d;

  // Occupancy flags and handshake qualifiers from registered state.
  always_comb begin
    wr_idx = wr_ptr_q[PTR_SIZE-1:0];
    empty  = (wr_ptr_q == rd_ptr_q);
    full   = (wr_ptr_q[PTR_SIZE] != rd_ptr_q[PTR_SIZE]) &&
             (wr_ptr_q[PTR_SIZE-1:0] == rd_ptr_q[PTR_SIZE-1:0]);
    pop    = tx_valid_q && tx.tx_ready;
    push   = out_enable && (!full || pop);
    drop   = out_enable && full && !pop;
  end

  // Next pointers, next head byte and overflow.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tx_data_d  = 8'h00;
    tx_valid_d = 1'b0;
    overflow_d = overflow_q;

    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

    rd_idx_d   = rd_ptr_d[PTR_SIZE-1:0];
    tx_valid_d = (wr_ptr_d != rd_ptr_d);

    // The head slot is only being written this cycle when the FIFO becomes
    // empty-then-refilled, so the incoming byte becomes the new head directly.
    if (tx_valid_d) begin
      if (push && (wr_idx == rd_idx_d)) tx_data_d = out;
      else                              tx_data_d = mem_q[rd_idx_d];
    end

    if (drop)                overflow_d = 1'b1;
    else if (overflow_clear) overflow_d = 1'b0;
  end

  // Drain tracker next-state logic.
  always_comb begin
    state_d   = state_q;
    drained_d = (state_q == ST_DONE) && empty;
    case (state_q)
      ST_RUN: begin
        if (halted) state_d = empty ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!halted)    state_d = ST_RUN;
        else if (empty) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!halted)     state_d = ST_RUN;
        else if (!empty) state_d = ST_DRAIN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      drained_q  <= 1'b0;
      state_q    <= ST_RUN;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      overflow_q <= overflow_d;
      drained_q  <= drained_d;
      state_q    <= state_d;
    end
  end

  // Storage; contents are never exposed while empty, so no reset.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_idx] <= out;
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign overflow    = overflow_q;
  assign drained     = drained_q;

`ifdef BF_OUT_FIFO_COUNT_EN
  assign count       = wr_ptr_q - rd_ptr_q;
  assign almost_full = (count >= PW'(DEPTH - 2));
`endif

endmodule

// File: tb/tb_bf_out_fifo.sv
// Directed + randomized bench for bf_out_fifo against a queue-based reference model.
module tb_bf_out_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int MS_RUN   = 0;
  localparam int MS_DRAIN = 1;
  localparam int MS_DONE  = 2;

  logic       clock;
  logic       reset_n;
  logic [7:0] out_b;
  logic       out_enable;
  logic       halted;
  logic       overflow_clear;
  logic       overflow;
  logic       drained;
`ifdef BF_OUT_FIFO_COUNT_EN
  logic [$clog2(DEPTH):0] count;
  logic                   almost_full;
`endif

  bf_out_fifo_if tx ();

  bf_out_fifo #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .out            (out_b),
    .out_enable     (out_enable),
    .halted         (halted),
    .tx             (tx),
    .overflow       (overflow),
    .overflow_clear (overflow_clear),
    .drained        (drained)
`ifdef BF_OUT_FIFO_COUNT_EN
    ,
    .count          (count),
    .almost_full    (almost_full)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit         m_ov;
  bit         m_drained;
  int         m_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ov      = 1'b0;
    m_drained = 1'b0;
    m_st      = MS_RUN;
  endtask

  // One clock edge of the specified behaviour, using the inputs the DUT sampled.
  task automatic model_edge();
    bit pop_m, full_m, empty_m, dropped;
    empty_m   = (mq.size() == 0);
    full_m    = (mq.size() == DEPTH);
    pop_m     = !empty_m && tx.tx_ready;
    dropped   = 1'b0;
    m_drained = (m_st == MS_DONE) && empty_m;
    case (m_st)
      MS_RUN:   if (halted) m_st = empty_m ? MS_DONE : MS_DRAIN;
      MS_DRAIN: if (!halted) m_st = MS_RUN; else if (empty_m) m_st = MS_DONE;
      default:  if (!halted) m_st = MS_RUN; else if (!empty_m) m_st = MS_DRAIN;
    endcase
    if (pop_m) void'(mq.pop_front());
    if (out_enable) begin
      if (!full_m || pop_m) mq.push_back(out_b);
      else                  dropped = 1'b1;
    end
    if (dropped)             m_ov = 1'b1;
    else if (overflow_clear) m_ov = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] head;
    head = (mq.size() != 0) ? mq[0] : 8'h00;
    chk({tag, "_valid"},    32'(tx.tx_valid), 32'(mq.size() != 0));
    chk({tag, "_data"},     32'(tx.tx_data),  32'(head));
    chk({tag, "_overflow"}, 32'(overflow),    32'(m_ov));
    chk({tag, "_drained"},  32'(drained),     32'(m_drained));
`ifdef BF_OUT_FIFO_COUNT_EN
    chk({tag, "_count"},    32'(count),       32'(mq.size()));
    chk({tag, "_afull"},    32'(almost_full), 32'(mq.size() >= DEPTH - 2));
`endif
  endtask

  task automatic step(input string tag, input logic oe, input logic [7:0] b,
                      input logic rdy, input logic clr, input logic hlt);
    @(negedge clock);
    out_enable     = oe;
    out_b          = b;
    tx.tx_ready    = rdy;
    overflow_clear = clr;
    halted         = hlt;
    @(posedge clock);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset_n        = 1'b1;
    out_enable     = 1'b0;
    tx.tx_ready    = 1'b0;
    overflow_clear = 1'b0;
    halted         = 1'b0;
    @(posedge clock);
    model_edge();
    #1;
    check_all("post_reset");
  endtask

  initial begin
    logic oe_r, rdy_r, clr_r, hlt_r;
    reset_n        = 1'b0;
    out_b          = 8'h00;
    out_enable     = 1'b0;
    halted         = 1'b0;
    overflow_clear = 1'b0;
    tx.tx_ready    = 1'b0;
    model_reset();

    #3;
    check_all("reset");
    release_reset();

    // 1: single push, held while sink stalls
    step("t1_push", 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    chk("t1_head", 32'(tx.tx_data), 32'h41);
    for (int i = 0; i < 5; i++) step("t1_hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step("t1_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 2: fill, overrun, drain in order
    for (int i = 1; i <= 16; i++) step("t2_fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    step("t2_drop", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("t2_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) step("t2_drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    step("t2_clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // 3: push into full FIFO while popping
    for (int i = 0; i < 16; i++) step("t3_fill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    step("t3_swap", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("t3_noovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 16; i++) step("t3_drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 4: streaming through pointer wraps
    for (int i = 0; i < 40; i++) step("t4_stream", 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("t4_tail", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // 5: drain tracking on halt
    for (int i = 0; i < 3; i++) step("t5_push", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step("t5_halt", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("t5_drained", 32'(drained), 32'd1);
    for (int i = 0; i < 3; i++) step("t5_run", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t5_undrained", 32'(drained), 32'd0);

    // 6: drop beats clear; reset with buffered bytes
    for (int i = 0; i < 16; i++) step("t6_fill", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    step("t6_dropclr", 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    chk("t6_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 11; i++) step("t6_part", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_async_rst");
    chk("t6_rst_valid", 32'(tx.tx_valid), 32'd0);
    release_reset();
    step("t6_first", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    step("t6_first_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Randomized traffic
    hlt_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      oe_r  = ($urandom_range(0, 99) < 60);
      rdy_r = ($urandom_range(0, 99) < 45);
      clr_r = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 3) hlt_r = ~hlt_r;
      step("rand", oe_r, 8'($urandom), rdy_r, clr_r, hlt_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
